// File: rtl/id_ex_skid_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// id_ex_skid_stage : ID->EX register with valid/ready, 2-entry skid, WB refresh
// Rev 1.0 | optional STALL_CNT_EN adds stall_cycles/stall_clr
// ---------------------------------------------------------------------------
module id_ex_skid_stage #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 24,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_pc,
  input  logic [DATA_W-1:0]  in_instr,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_rs_data,
  input  logic [DATA_W-1:0]  in_rt_data,
  input  logic               wb_en,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
`ifdef STALL_CNT_EN
  input  logic               stall_clr,
  output logic [31:0]        stall_cycles,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_pc,
  output logic [DATA_W-1:0]  out_instr,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_rs_data,
  output logic [DATA_W-1:0]  out_rt_data
);

  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t state, state_next;

  logic main_valid, skid_valid;
  logic accept, issue;
  logic main_load_in, main_load_skid, skid_load_in;

  logic [DATA_W-1:0] main_pc, main_instr, main_rs, main_rt;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_pc, skid_instr, skid_rs, skid_rt;
  logic [CTRL_W-1:0] skid_ctrl;

  // Operand bypass from writeback; r0 is hard-wired and never refreshed.
  function automatic logic [DATA_W-1:0] refresh_op(
    input logic [RADDR_W-1:0] addr,
    input logic [DATA_W-1:0]  data,
    input logic               en,
    input logic [RADDR_W-1:0] waddr,
    input logic [DATA_W-1:0]  wdata
  );
    if (en && (waddr != '0) && (waddr == addr)) return wdata;
    return data;
  endfunction

  logic [DATA_W-1:0] cap_rs, cap_rt, main_rs_fresh, main_rt_fresh;
  logic [DATA_W-1:0] skid_rs_fresh, skid_rt_fresh;

  assign cap_rs        = refresh_op(in_instr[RS_LSB +: RADDR_W], in_rs_data, wb_en, wb_addr, wb_data);
  assign cap_rt        = refresh_op(in_instr[RT_LSB +: RADDR_W], in_rt_data, wb_en, wb_addr, wb_data);
  assign main_rs_fresh = refresh_op(main_instr[RS_LSB +: RADDR_W], main_rs, wb_en, wb_addr, wb_data);
  assign main_rt_fresh = refresh_op(main_instr[RT_LSB +: RADDR_W], main_rt, wb_en, wb_addr, wb_data);
  assign skid_rs_fresh = refresh_op(skid_instr[RS_LSB +: RADDR_W], skid_rs, wb_en, wb_addr, wb_data);
  assign skid_rt_fresh = refresh_op(skid_instr[RT_LSB +: RADDR_W], skid_rt, wb_en, wb_addr, wb_data);

  assign main_valid = state[1];
  assign skid_valid = state[0];
  assign in_ready   = !skid_valid;
  assign accept     = in_valid && in_ready;
  assign issue      = main_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load_in   = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next   = ONE;
          main_load_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && issue) begin
          main_load_in = 1'b1;
        end else if (accept) begin
          state_next   = FULL;
          skid_load_in = 1'b1;
        end else if (issue) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (issue) begin
          state_next     = ONE;
          main_load_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Flush overrides everything; any same-cycle issue has already left.
    if (flush) begin
      state_next     = EMPTY;
      main_load_in   = 1'b0;
      main_load_skid = 1'b0;
      skid_load_in   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_pc    <= '0;
      main_instr <= '0;
      main_ctrl  <= '0;
      main_rs    <= '0;
      main_rt    <= '0;
    end else if (flush) begin
      main_pc    <= '0;
      main_instr <= '0;
      main_ctrl  <= '0;
      main_rs    <= '0;
      main_rt    <= '0;
    end else if (main_load_in) begin
      main_pc    <= in_pc;
      main_instr <= in_instr;
      main_ctrl  <= in_ctrl;
      main_rs    <= cap_rs;
      main_rt    <= cap_rt;
    end else if (main_load_skid) begin
      main_pc    <= skid_pc;
      main_instr <= skid_instr;
      main_ctrl  <= skid_ctrl;
      main_rs    <= skid_rs_fresh;
      main_rt    <= skid_rt_fresh;
    end else if (main_valid) begin
      main_rs    <= main_rs_fresh;
      main_rt    <= main_rt_fresh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_pc    <= '0;
      skid_instr <= '0;
      skid_ctrl  <= '0;
      skid_rs    <= '0;
      skid_rt    <= '0;
    end else if (flush) begin
      skid_pc    <= '0;
      skid_instr <= '0;
      skid_ctrl  <= '0;
      skid_rs    <= '0;
      skid_rt    <= '0;
    end else if (skid_load_in) begin
      skid_pc    <= in_pc;
      skid_instr <= in_instr;
      skid_ctrl  <= in_ctrl;
      skid_rs    <= cap_rs;
      skid_rt    <= cap_rt;
    end else if (skid_valid) begin
      skid_rs    <= skid_rs_fresh;
      skid_rt    <= skid_rt_fresh;
    end
  end

  assign out_valid   = main_valid;
  assign out_pc      = main_pc;
  assign out_instr   = main_instr;
  assign out_ctrl    = main_ctrl;
  assign out_rs_data = main_rs;
  assign out_rt_data = main_rt;

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         stall_cnt <= '0;
    else if (stall_clr)                                 stall_cnt <= '0;
    else if (main_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF))
                                                        stall_cnt <= stall_cnt + 32'd1;
  end

  assign stall_cycles = stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_skid_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_id_ex_skid_stage : directed self-checking bench for id_ex_skid_stage
// ---------------------------------------------------------------------------
module tb_id_ex_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_instr, in_rs_data, in_rt_data;
  logic [23:0] in_ctrl;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_instr, out_rs_data, out_rt_data;
  logic [23:0] out_ctrl;
`ifdef STALL_CNT_EN
  logic        stall_clr;
  logic [31:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_skid_stage #(.DATA_W(32), .CTRL_W(24), .RADDR_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .in_ctrl    (in_ctrl),
    .in_rs_data (in_rs_data),
    .in_rt_data (in_rt_data),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
`ifdef STALL_CNT_EN
    .stall_clr    (stall_clr),
    .stall_cycles (stall_cycles),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_ctrl   (out_ctrl),
    .out_rs_data(out_rs_data),
    .out_rt_data(out_rt_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] rs, input logic [31:0] rt);
    in_valid   = 1'b1;
    in_pc      = pc;
    in_instr   = instr;
    in_ctrl    = pc[23:0] ^ 24'hA5A5A5;
    in_rs_data = rs;
    in_rt_data = rt;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0; in_ctrl = '0; in_rs_data = '0; in_rt_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
`ifdef STALL_CNT_EN
    stall_clr = 1'b0;
`endif
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_pc",    out_pc,    32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single accept, immediate issue
    out_ready = 1'b1;
    drive(32'h100, 32'h012A4020, 32'h11, 32'h22);
    tick();
    in_valid = 1'b0;
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_pc",    out_pc,    32'h100);
    check("single_instr", out_instr, 32'h012A4020);
    check("single_ctrl",  {8'd0, out_ctrl}, {8'd0, 24'h000100 ^ 24'hA5A5A5});
    check("single_rs",    out_rs_data, 32'h11);
    check("single_rt",    out_rt_data, 32'h22);
    tick();
    check("single_drain", {31'd0, out_valid}, 32'd0);

    // Back-pressure fills the skid, then drains in order
    out_ready = 1'b0;
    drive(32'h200, 32'h00430820, 32'h1, 32'h2);
    tick();
    check("bp_one_pc", out_pc, 32'h200);
    drive(32'h204, 32'h00851020, 32'h3, 32'h4);
    tick();
    in_valid = 1'b0;
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    check("bp_full_pc",    out_pc, 32'h200);
    out_ready = 1'b1;
    tick();
    check("bp_second_valid", {31'd0, out_valid}, 32'd1);
    check("bp_second_pc",    out_pc, 32'h204);
    check("bp_second_rs",    out_rs_data, 32'h3);
    check("bp_ready_back",   {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_drain", {31'd0, out_valid}, 32'd0);

    // Stalled main entry refreshed by writeback (rs=8, rt=7)
    out_ready = 1'b0;
    drive(32'h240, 32'h01070000, 32'h1, 32'h2);
    tick();
    in_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'hDEADBEEF;
    tick();
    wb_en = 1'b0;
    check("stall_ref_rs", out_rs_data, 32'hDEADBEEF);
    check("stall_ref_rt", out_rt_data, 32'h2);
    out_ready = 1'b1;
    tick();
    check("stall_ref_drain", {31'd0, out_valid}, 32'd0);

    // Skid entry refreshed while held, then again while moving to main
    out_ready = 1'b0;
    drive(32'h300, 32'h01070000, 32'h1, 32'h2);
    tick();
    drive(32'h304, 32'h00E80000, 32'h3, 32'h4);
    tick();
    in_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'hCAFE0001;
    tick();
    check("skid_main_rs", out_rs_data, 32'hCAFE0001);
    wb_addr = 5'd7; wb_data = 32'h77;
    out_ready = 1'b1;
    tick();
    wb_en = 1'b0;
    check("skid_move_pc", out_pc, 32'h304);
    check("skid_move_rs", out_rs_data, 32'h77);
    check("skid_move_rt", out_rt_data, 32'hCAFE0001);
    tick();
    check("skid_drain", {31'd0, out_valid}, 32'd0);

    // Capture refresh on r9, then r0 write ignored on capture
    out_ready = 1'b0;
    drive(32'h340, 32'h01290000, 32'hA, 32'hB);
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
    tick();
    check("cap_rs", out_rs_data, 32'h55);
    check("cap_rt", out_rt_data, 32'h55);
    out_ready = 1'b1;
    drive(32'h344, 32'h00000020, 32'hA, 32'hB);
    wb_addr = 5'd0;
    tick();
    in_valid = 1'b0; wb_en = 1'b0;
    check("r0_pc", out_pc, 32'h344);
    check("r0_rs", out_rs_data, 32'hA);
    check("r0_rt", out_rt_data, 32'hB);
    tick();

    // Flush in FULL with an incoming instruction
    out_ready = 1'b0;
    drive(32'h400, 32'h00430820, 32'h1, 32'h2);
    tick();
    drive(32'h404, 32'h00851020, 32'h3, 32'h4);
    tick();
    drive(32'h408, 32'h00C63020, 32'h5, 32'h6);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_instr", out_instr, 32'd0);
    check("flush_pc",    out_pc,    32'd0);
    check("flush_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("flush_no_ghost", {31'd0, out_valid}, 32'd0);

`ifdef STALL_CNT_EN
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    out_ready = 1'b0;
    drive(32'h500, 32'h00430820, 32'h1, 32'h2);
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    check("stall_cnt_7", stall_cycles, 32'd7);
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    check("stall_cnt_clr", stall_cycles, 32'd0);
    out_ready = 1'b1;
    tick();
`endif

    // Asynchronous reset while FULL discards both entries
    out_ready = 1'b0;
    drive(32'h600, 32'h00430820, 32'h1, 32'h2);
    tick();
    drive(32'h604, 32'h00851020, 32'h3, 32'h4);
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_ready", {31'd0, in_ready},  32'd1);
    check("arst_pc",    out_pc, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("arst_no_ghost", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_skid_stage.md
Name: id_ex_skid_stage

Overview:
- Parametrised decode-to-execute boundary register, successor to the single-entry ID pipeline register.
- Adds a valid/ready handshake and a 2-entry skid buffer, so back-pressure from EX never drops or duplicates an instruction.
- Operands held while stalled are refreshed by writeback, so stalled entries never carry stale register data.
- Sits between decode logic (MainControlUnit, ALUControlUnit, RegisterFile) and the EX stage.

Parameters:
DATA_W, 32, width of PC, instruction and operand data
CTRL_W, 24, width of packed decoded control bundle (regDst..useSign, aluOp, mMask)
RADDR_W, 5, register address width; rs field = instr[25:21], rt field = instr[20:16]

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill all held and incoming entries this cycle
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept; registered; equals !skid_valid
in_pc  in  DATA_W  PC of decoded instruction
in_instr  in  DATA_W  raw instruction
in_ctrl  in  CTRL_W  decoded control bundle
in_rs_data  in  DATA_W  register-file rs read
in_rt_data  in  DATA_W  register-file rt read
wb_en  in  1  writeback enable
wb_addr  in  RADDR_W  writeback register
wb_data  in  DATA_W  writeback value
out_valid  out  1  main entry valid
out_ready  in  1  EX accepts main entry
out_pc  out  DATA_W  main entry PC
out_instr  out  DATA_W  main entry instruction
out_ctrl  out  CTRL_W  main entry control
out_rs_data  out  DATA_W  main entry rs operand
out_rt_data  out  DATA_W  main entry rt operand

Behaviour:
- Reset (rst_n low, async): main_valid=0, skid_valid=0, all payload regs 0, in_ready=1 after reset, out_* = 0. Reset mid-transfer discards both entries.
- Storage: main entry drives out_*; skid entry holds at most one overflow instruction.
- Input transfer (accept) = in_valid && in_ready. Output transfer (issue) = out_valid && out_ready.
- Latency: accepted instruction appears on out_* the next cycle if the main entry is empty or issuing; else it lands in skid.
- States, as {main_valid, skid_valid}:
  - EMPTY 00: accept -> 10.
  - ONE 10: accept with issue -> 10, new data to main. Accept without issue -> 11, new data to skid. Issue without accept -> 00. Neither -> hold.
  - FULL 11: in_ready=0. Issue -> 10, skid moves to main. No issue -> hold. State 01 is illegal.
- Ordering: instructions issue strictly in accept order; no duplication, no loss.
- Flush has highest priority after reset.
  - Next cycle both valids are 0 and payloads are zeroed (bubble = instr 0, ctrl 0).
  - Any same-cycle accept is dropped and any same-cycle issue still completes from EX's view.
- Writeback refresh: every cycle, for each valid entry (main and skid) and for the incoming captured data, independently per operand:
  - if wb_en && wb_addr!=0 && wb_addr==entry rs field, the rs operand <= wb_data; same rule for rt.
  - Refresh on capture takes precedence over in_rs_data/in_rt_data.
  - Refresh applies during skid->main moves, using the moving entry's fields.
- Register 0 is never refreshed (wb_addr==0 ignored).
- No arithmetic on data; ctrl passes bit-exact.

Optional Feature:
STALL_CNT_EN
- Defined: adds output stall_cycles [31:0] and input stall_clr.
  - Counter increments each cycle with out_valid && !out_ready; it saturates at 0xFFFFFFFF.
  - stall_clr or rst_n low sets it to 0. Clear wins over increment.
  - Flush does not clear it.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then single accept: in_pc=0x100, in_instr=0x012A4020, out_ready=1 -> next cycle out_valid=1, out_pc=0x100; following cycle out_valid=0.
- Back-pressure: out_ready=0, accept 0x200 then 0x204 -> state FULL, in_ready=0. Raise out_ready -> issues 0x200 then 0x204 on consecutive cycles, in_ready=1 after the first issue.
- Stalled refresh: entry with rs=8 held (out_ready=0), wb_en=1, wb_addr=8, wb_data=0xDEADBEEF -> next cycle out_rs_data=0xDEADBEEF, out_rt_data unchanged.
- Capture refresh and r0: accept rs=rt=9 while wb writes r9=0x55 -> out_rs_data=out_rt_data=0x55. Repeat with wb_addr=0 -> operands equal in_rs_data/in_rt_data.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_instr=0, in_ready=1; dropped instruction never appears.
- STALL_CNT_EN: hold out_valid=1, out_ready=0 for 7 cycles -> stall_cycles=7; pulse stall_clr -> stall_cycles=0.
